// File: rtl/cl_tx_pkg.sv
// cl_tx_pkg: definitions shared by the cluster packet transmitter.
//   - default channel count and header tag
//   - FSM state encoding (ST_CNT exists only with CL_TX_FRAMECNT_EN defined)
//   - header field positions and a helper that packs the header word
// Optional feature macro: CL_TX_FRAMECNT_EN (frame-counter word after header).
package cl_tx_pkg;

  localparam int         NUM_CH_DEFAULT = 320;
  localparam logic [3:0] MAGIC_DEFAULT  = 4'hA;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  // Header word layout
  localparam int HDR_MAGIC_LSB = 28;  // [31:28]
  localparam int HDR_HAS_BIT   = 27;
  localparam int HDR_ERR_BIT   = 26;
  localparam int HDR_LEFT_LSB  = 17;  // [25:17]
  localparam int HDR_RIGHT_LSB = 8;   // [16:8]

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
`ifdef CL_TX_FRAMECNT_EN
    ,
    ST_CNT  = 2'd3
`endif
  } state_e;

  function automatic logic [DATA_W-1:0] build_header(
    input logic [3:0]        magic,
    input logic              has,
    input logic              err,
    input logic [ADDR_W-1:0] left,
    input logic [ADDR_W-1:0] right
  );
    logic [DATA_W-1:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 4]      = magic;
    h[HDR_HAS_BIT]             = has;
    h[HDR_ERR_BIT]             = err;
    h[HDR_LEFT_LSB +: ADDR_W]  = left;
    h[HDR_RIGHT_LSB +: ADDR_W] = right;
    return h;
  endfunction

endpackage

// File: rtl/cl_tx_buf.sv
// cl_tx_buf: 512x32 simple dual-port sample buffer.
// Ports:
//   clk        sole clock
//   wr_en_i    write strobe, wr_addr_i / wr_data_i write address and data
//   rd_en_i    read strobe, rd_addr_i read address
//   rd_data_o  read data, valid one cycle after rd_en_i; holds while rd_en_i=0
// No reset: contents and read register are intentionally left uninitialised.
module cl_tx_buf
  import cl_tx_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/cl_packet_tx.sv
// cl_packet_tx: buffers calibrated samples per channel and, on a cluster
// decision, emits one Avalon-ST packet (header, optional frame count, then
// the cluster's samples).
// Ports:
//   clk, rst                      clock, async active-high reset
//   data_caled_valid/_address/    sample write into the channel buffer
//   data_caled                    (accepted only while idle, address < NUM_CH)
//   has_cluster, no_cluster       decision pulses; sig_ch_left/right = cluster span
//   data_out_*                    Avalon-ST source, readyLatency 0
//   drop_cnt                      saturating count of pulses seen while busy
// Optional feature macro: CL_TX_FRAMECNT_EN inserts a 32-bit frame-counter
// word after the header.
//
// state | meaning
// IDLE  | accepting sample writes, waiting for a decision pulse
// HDR   | header word presented
// CNT   | frame-counter word presented (CL_TX_FRAMECNT_EN only)
// DATA  | cluster samples presented, buffer[ptr_q] on the output
module cl_packet_tx
  import cl_tx_pkg::*;
#(
  parameter int         NUM_CH = NUM_CH_DEFAULT,
  parameter logic [3:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_caled_valid,
  input  logic [ADDR_W-1:0] data_caled_address,
  input  logic [DATA_W-1:0] data_caled,
  input  logic              has_cluster,
  input  logic              no_cluster,
  input  logic [ADDR_W-1:0] sig_ch_left,
  input  logic [ADDR_W-1:0] sig_ch_right,
  output logic [DATA_W-1:0] data_out_data,
  input  logic              data_out_ready,
  output logic              data_out_valid,
  output logic [1:0]        data_out_empty,
  output logic              data_out_startofpacket,
  output logic              data_out_endofpacket,
  output logic [15:0]       drop_cnt
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] left_q, left_d;
  logic [ADDR_W-1:0] right_q, right_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              has_q, has_d;
  logic              err_q, err_d;
  logic [15:0]       drop_q, drop_d;
`ifdef CL_TX_FRAMECNT_EN
  logic [31:0]       frame_q, frame_d;
`endif

  logic              pulse;
  logic              fire;
  logic              hdr_only;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [DATA_W-1:0] rd_data;

  assign pulse    = has_cluster | no_cluster;
  assign fire     = data_out_valid & data_out_ready;
  // Packet carries no samples: no_cluster, or an invalid cluster span
  assign hdr_only = ~has_q | err_q;
  assign ptr_nxt  = ptr_q + 1'b1;
  assign wr_en    = data_caled_valid && (state_q == ST_IDLE) &&
                    (int'(data_caled_address) < NUM_CH);

  cl_tx_buf u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (data_caled_address),
    .wr_data_i (data_caled),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      left_q  <= '0;
      right_q <= '0;
      ptr_q   <= '0;
      has_q   <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= '0;
`ifdef CL_TX_FRAMECNT_EN
      frame_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
      ptr_q   <= ptr_d;
      has_q   <= has_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
`ifdef CL_TX_FRAMECNT_EN
      frame_q <= frame_d;
`endif
    end
  end

  // Next-state logic. The buffer read for the next sample is issued on the
  // same edge that retires the current word, so rd_data is ready exactly when
  // DATA needs it and one word per cycle is sustained.
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    right_d = right_q;
    ptr_d   = ptr_q;
    has_d   = has_q;
    err_d   = err_q;
    drop_d  = drop_q;
    rd_en   = 1'b0;
    rd_addr = ptr_nxt;
`ifdef CL_TX_FRAMECNT_EN
    frame_d = frame_q;
    if (fire && data_out_endofpacket) begin
      frame_d = frame_q + 32'd1;
    end
`endif

    // Pulses outside IDLE (including the eop beat cycle) are dropped
    if (pulse && (state_q != ST_IDLE) && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (pulse) begin
          state_d = ST_HDR;
          left_d  = sig_ch_left;
          right_d = sig_ch_right;
          has_d   = has_cluster;
          err_d   = has_cluster & ((sig_ch_left > sig_ch_right) ||
                                   (int'(sig_ch_right) >= NUM_CH));
        end
      end
      ST_HDR: begin
        if (fire) begin
`ifdef CL_TX_FRAMECNT_EN
          state_d = ST_CNT;
`else
          if (hdr_only) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            rd_en   = 1'b1;
            rd_addr = left_q;
            ptr_d   = left_q;
          end
`endif
        end
      end
`ifdef CL_TX_FRAMECNT_EN
      ST_CNT: begin
        if (fire) begin
          if (hdr_only) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            rd_en   = 1'b1;
            rd_addr = left_q;
            ptr_d   = left_q;
          end
        end
      end
`endif
      ST_DATA: begin
        if (fire) begin
          if (ptr_q == right_q) begin
            state_d = ST_IDLE;
          end else begin
            rd_en = 1'b1;
            ptr_d = ptr_nxt;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so they hold under backpressure
  always_comb begin
    data_out_valid         = 1'b0;
    data_out_startofpacket = 1'b0;
    data_out_endofpacket   = 1'b0;
    data_out_data          = '0;
    case (state_q)
      ST_HDR: begin
        data_out_valid         = 1'b1;
        data_out_startofpacket = 1'b1;
        data_out_data          = build_header(MAGIC, has_q, err_q, left_q, right_q);
`ifndef CL_TX_FRAMECNT_EN
        data_out_endofpacket   = hdr_only;
`endif
      end
`ifdef CL_TX_FRAMECNT_EN
      ST_CNT: begin
        data_out_valid       = 1'b1;
        data_out_endofpacket = hdr_only;
        data_out_data        = frame_q;
      end
`endif
      ST_DATA: begin
        data_out_valid       = 1'b1;
        data_out_endofpacket = (ptr_q == right_q);
        data_out_data        = rd_data;
      end
      default: ;
    endcase
  end

  assign data_out_empty = 2'b00;
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_cl_packet_tx.sv
module tb_cl_packet_tx;

  logic        clk;
  logic        rst;
  logic        data_caled_valid;
  logic [8:0]  data_caled_address;
  logic [31:0] data_caled;
  logic        has_cluster;
  logic        no_cluster;
  logic [8:0]  sig_ch_left;
  logic [8:0]  sig_ch_right;
  logic [31:0] data_out_data;
  logic        data_out_ready;
  logic        data_out_valid;
  logic [1:0]  data_out_empty;
  logic        data_out_startofpacket;
  logic        data_out_endofpacket;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_frames = 0;

  logic [31:0] cap_data[$];
  logic        cap_sop[$];
  logic        cap_eop[$];
  int          cap_cyc[$];
  int          hold_bad;
  logic        cap_timeout;
  logic [31:0] exp_data[$];

  cl_packet_tx dut (
    .clk                    (clk),
    .rst                    (rst),
    .data_caled_valid       (data_caled_valid),
    .data_caled_address     (data_caled_address),
    .data_caled             (data_caled),
    .has_cluster            (has_cluster),
    .no_cluster             (no_cluster),
    .sig_ch_left            (sig_ch_left),
    .sig_ch_right           (sig_ch_right),
    .data_out_data          (data_out_data),
    .data_out_ready         (data_out_ready),
    .data_out_valid         (data_out_valid),
    .data_out_empty         (data_out_empty),
    .data_out_startofpacket (data_out_startofpacket),
    .data_out_endofpacket   (data_out_endofpacket),
    .drop_cnt               (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic has, input logic no, input int l, input int r);
    has_cluster  = has;
    no_cluster   = no;
    sig_ch_left  = 9'(l);
    sig_ch_right = 9'(r);
    step();
    has_cluster = 1'b0;
    no_cluster  = 1'b0;
  endtask

  // Step through the frame-counter word when that feature is built in
  task automatic skip_cnt();
`ifdef CL_TX_FRAMECNT_EN
    data_out_ready = 1'b1;
    step();
`endif
  endtask

  // Record accepted beats until eop; cycle 0 is the cycle after the pulse edge
  task automatic capture(input bit toggle, input int max_cyc);
    logic [31:0] hd;
    logic        hs, he;
    bit          pend;
    cap_data.delete(); cap_sop.delete(); cap_eop.delete(); cap_cyc.delete();
    hold_bad = 0; pend = 0; cap_timeout = 1'b1;
    hd = '0; hs = 1'b0; he = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      data_out_ready = toggle ? c[0] : 1'b1;
      if (pend && (data_out_valid !== 1'b1 || data_out_data !== hd ||
                   data_out_startofpacket !== hs || data_out_endofpacket !== he))
        hold_bad++;
      pend = 0;
      if (data_out_valid && !data_out_ready) begin
        hd = data_out_data; hs = data_out_startofpacket; he = data_out_endofpacket;
        pend = 1;
      end
      if (data_out_valid && data_out_ready) begin
        cap_data.push_back(data_out_data);
        cap_sop.push_back(data_out_startofpacket);
        cap_eop.push_back(data_out_endofpacket);
        cap_cyc.push_back(c);
        if (data_out_endofpacket) begin
          step();
          data_out_ready = 1'b1;
          cap_timeout = 1'b0;
          return;
        end
      end
      step();
    end
    data_out_ready = 1'b1;
  endtask

  task automatic build_exp(input logic [31:0] hdr, input bit dat, input int l, input int r);
    exp_data.delete();
    exp_data.push_back(hdr);
`ifdef CL_TX_FRAMECNT_EN
    exp_data.push_back(32'(exp_frames));
`endif
    if (dat) for (int k = l; k <= r; k++) exp_data.push_back(32'(k));
    exp_frames++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_caled_valid = 1'b0; data_caled_address = '0; data_caled = '0;
    has_cluster = 1'b0; no_cluster = 1'b0; sig_ch_left = '0; sig_ch_right = '0;
    data_out_ready = 1'b1;
    step(); step();
    n_cmp++; if (data_out_valid !== 1'b0) begin n_mis++; $display("FAIL reset valid: got %b want 0", data_out_valid); end
    n_cmp++; if (data_out_startofpacket !== 1'b0 || data_out_endofpacket !== 1'b0) begin n_mis++; $display("FAIL reset sop/eop: got %b/%b want 0/0", data_out_startofpacket, data_out_endofpacket); end
    n_cmp++; if (data_out_data !== 32'h0) begin n_mis++; $display("FAIL reset data: got %h want 0", data_out_data); end
    n_cmp++; if (drop_cnt !== 16'h0) begin n_mis++; $display("FAIL reset drop_cnt: got %h want 0", drop_cnt); end
    n_cmp++; if (data_out_empty !== 2'b00) begin n_mis++; $display("FAIL reset empty: got %b want 0", data_out_empty); end
    rst = 1'b0;
    step();
    for (int i = 0; i < 320; i++) begin
      data_caled_valid = 1'b1; data_caled_address = 9'(i); data_caled = 32'(i);
      step();
    end
    data_caled_valid = 1'b0;
  endtask

  typedef struct {
    bit          has;
    bit          no;
    int          l;
    int          r;
    logic [31:0] hdr;
    bit          dat;
  } vec_t;

  task automatic test_packets();
    vec_t v[7];
    v[0] = '{1, 0, 10, 13, 32'hA8140D00, 1};   // basic cluster
    v[1] = '{0, 1, 0, 0, 32'hA0000000, 0};     // no cluster
    v[2] = '{1, 0, 20, 5, 32'hAC280500, 0};    // left > right
    v[3] = '{1, 0, 0, 320, 32'hAC014000, 0};   // right out of range
    v[4] = '{1, 1, 10, 13, 32'hA8140D00, 1};   // both pulses -> cluster
    v[5] = '{1, 0, 319, 319, 32'hAA7F3F00, 1}; // last channel
    v[6] = '{1, 0, 0, 0, 32'hA8000000, 1};     // first channel
    for (int p = 0; p < 7; p++) begin
      build_exp(v[p].hdr, v[p].dat, v[p].l, v[p].r);
      pulse(v[p].has, v[p].no, v[p].l, v[p].r);
      capture(0, 400);
      n_cmp++; if (cap_timeout !== 1'b0) begin n_mis++; $display("FAIL pkt%0d timeout: got no eop want eop", p); end
      n_cmp++; if (cap_data.size() != exp_data.size()) begin n_mis++; $display("FAIL pkt%0d length: got %0d want %0d", p, cap_data.size(), exp_data.size()); end
      for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
        n_cmp++; if (cap_data[i] !== exp_data[i]) begin n_mis++; $display("FAIL pkt%0d word%0d data: got %h want %h", p, i, cap_data[i], exp_data[i]); end
        n_cmp++; if (cap_sop[i] !== (i == 0)) begin n_mis++; $display("FAIL pkt%0d word%0d sop: got %b want %b", p, i, cap_sop[i], (i == 0)); end
        n_cmp++; if (cap_eop[i] !== (i == exp_data.size() - 1)) begin n_mis++; $display("FAIL pkt%0d word%0d eop: got %b want %b", p, i, cap_eop[i], (i == exp_data.size() - 1)); end
        n_cmp++; if (cap_cyc[i] != i) begin n_mis++; $display("FAIL pkt%0d word%0d cycle: got %0d want %0d", p, i, cap_cyc[i], i); end
      end
      n_cmp++; if (data_out_valid !== 1'b0) begin n_mis++; $display("FAIL pkt%0d idle after eop: valid got %b want 0", p, data_out_valid); end
    end
  endtask

  task automatic test_write_guard();
    data_caled_valid = 1'b1; data_caled_address = 9'd12; data_caled = 32'h12345678;
    step();
    data_caled_valid = 1'b0;
    data_out_ready = 1'b0;
    build_exp(32'hA8160C00, 0, 0, 0);
    exp_data.push_back(32'd11);
    exp_data.push_back(32'h12345678);
    pulse(1, 0, 11, 12);
    data_out_ready = 1'b0;
    data_caled_valid = 1'b1; data_caled_address = 9'd11; data_caled = 32'hDEADBEEF;
    step();
    data_caled_valid = 1'b0;
    n_cmp++; if (data_out_data !== 32'hA8160C00 || data_out_startofpacket !== 1'b1) begin n_mis++; $display("FAIL wg header held: got %h sop %b want a8160c00 sop 1", data_out_data, data_out_startofpacket); end
    capture(0, 50);
    n_cmp++; if (cap_data.size() != exp_data.size()) begin n_mis++; $display("FAIL wg length: got %0d want %0d", cap_data.size(), exp_data.size()); end
    for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
      n_cmp++; if (cap_data[i] !== exp_data[i]) begin n_mis++; $display("FAIL wg word%0d data: got %h want %h", i, cap_data[i], exp_data[i]); end
    end
    data_caled_valid = 1'b1; data_caled_address = 9'd12; data_caled = 32'd12;
    step();
    data_caled_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    build_exp(32'hA8140D00, 1, 10, 13);
    pulse(1, 0, 10, 13);
    capture(1, 100);
    n_cmp++; if (cap_timeout !== 1'b0) begin n_mis++; $display("FAIL bp timeout: got no eop want eop"); end
    n_cmp++; if (hold_bad != 0) begin n_mis++; $display("FAIL bp hold: got %0d unstable stalls want 0", hold_bad); end
    n_cmp++; if (cap_data.size() != exp_data.size()) begin n_mis++; $display("FAIL bp length: got %0d want %0d", cap_data.size(), exp_data.size()); end
    for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
      n_cmp++; if (cap_data[i] !== exp_data[i]) begin n_mis++; $display("FAIL bp word%0d data: got %h want %h", i, cap_data[i], exp_data[i]); end
      n_cmp++; if (cap_eop[i] !== (i == exp_data.size() - 1)) begin n_mis++; $display("FAIL bp word%0d eop: got %b want %b", i, cap_eop[i], (i == exp_data.size() - 1)); end
      n_cmp++; if (cap_cyc[i] != 2 * i + 1) begin n_mis++; $display("FAIL bp word%0d cycle: got %0d want %0d", i, cap_cyc[i], 2 * i + 1); end
    end
  endtask

  task automatic test_drop_and_reset();
    data_out_ready = 1'b1;
    pulse(1, 0, 10, 13);
    step();
    skip_cnt();
    n_cmp++; if (data_out_data !== 32'd10) begin n_mis++; $display("FAIL drop first data: got %h want a", data_out_data); end
    pulse(1, 0, 0, 1);
    n_cmp++; if (drop_cnt !== 16'd1) begin n_mis++; $display("FAIL drop count busy: got %0d want 1", drop_cnt); end
    n_cmp++; if (data_out_data !== 32'd11) begin n_mis++; $display("FAIL drop ignored pulse: got %h want b", data_out_data); end
    step(); step();
    n_cmp++; if (data_out_data !== 32'd13 || data_out_endofpacket !== 1'b1) begin n_mis++; $display("FAIL drop last word: got %h eop %b want d eop 1", data_out_data, data_out_endofpacket); end
    pulse(0, 1, 0, 0);
    n_cmp++; if (data_out_valid !== 1'b0 || drop_cnt !== 16'd2) begin n_mis++; $display("FAIL drop on eop beat: got valid %b drop %0d want 0/2", data_out_valid, drop_cnt); end
    step();
    n_cmp++; if (data_out_valid !== 1'b0) begin n_mis++; $display("FAIL drop no new packet: got valid %b want 0", data_out_valid); end

    pulse(1, 0, 10, 13);
    step();
    skip_cnt();
    data_out_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (data_out_valid !== 1'b0 || data_out_endofpacket !== 1'b0 || data_out_data !== 32'h0) begin n_mis++; $display("FAIL rst mid-data: got valid %b eop %b data %h want 0/0/0", data_out_valid, data_out_endofpacket, data_out_data); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_mis++; $display("FAIL rst drop_cnt: got %0d want 0", drop_cnt); end
    step();
    rst = 1'b0;
    data_out_ready = 1'b1;
    step();
    pulse(0, 1, 0, 0);
    n_cmp++; if (data_out_valid !== 1'b1 || data_out_startofpacket !== 1'b1 || data_out_data !== 32'hA0000000) begin n_mis++; $display("FAIL post-rst packet: got valid %b sop %b data %h want 1/1/a0000000", data_out_valid, data_out_startofpacket, data_out_data); end
`ifdef CL_TX_FRAMECNT_EN
    n_cmp++; if (data_out_endofpacket !== 1'b0) begin n_mis++; $display("FAIL post-rst hdr eop: got %b want 0", data_out_endofpacket); end
`else
    n_cmp++; if (data_out_endofpacket !== 1'b1) begin n_mis++; $display("FAIL post-rst hdr eop: got %b want 1", data_out_endofpacket); end
`endif
    step();
    skip_cnt();
    n_cmp++; if (data_out_valid !== 1'b0) begin n_mis++; $display("FAIL post-rst idle: got valid %b want 0", data_out_valid); end
  endtask

`ifdef CL_TX_FRAMECNT_EN
  task automatic test_framecnt();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      pulse(0, 1, 0, 0);
      capture(0, 20);
      n_cmp++; if (cap_data.size() != 2) begin n_mis++; $display("FAIL fc%0d length: got %0d want 2", k, cap_data.size()); end
      if (cap_data.size() == 2) begin
        n_cmp++; if (cap_data[0] !== 32'hA0000000 || cap_eop[0] !== 1'b0) begin n_mis++; $display("FAIL fc%0d header: got %h eop %b want a0000000 eop 0", k, cap_data[0], cap_eop[0]); end
        n_cmp++; if (cap_data[1] !== 32'(k) || cap_eop[1] !== 1'b1) begin n_mis++; $display("FAIL fc%0d count: got %h eop %b want %h eop 1", k, cap_data[1], cap_eop[1], 32'(k)); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_packets();
    test_write_guard();
    test_backpressure();
    test_drop_and_reset();
`ifdef CL_TX_FRAMECNT_EN
    test_framecnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cl_packet_tx.md
CL_PACKET_TX -- requirements
Module: cl_packet_tx

Interface
REQ-001 SHALL have parameter NUM_CH, default 320, number of sensor channels buffered per frame.
REQ-002 SHALL have parameter MAGIC, default 4'hA, header tag in bits [31:28].
REQ-003 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: data_caled_valid  in  1  calibrated-sample strobe; data_caled_address  in  9  channel index; data_caled  in  32  calibrated sample.
REQ-005 SHALL have ports: has_cluster  in  1  cluster-found pulse; no_cluster  in  1  no-cluster pulse; sig_ch_left  in  9  first cluster channel; sig_ch_right  in  9  last cluster channel.
REQ-006 SHALL have Avalon-ST source ports, readyLatency 0: data_out_data  out  32; data_out_ready  in  1; data_out_valid  out  1; data_out_empty  out  2; data_out_startofpacket  out  1; data_out_endofpacket  out  1.
REQ-007 SHALL have port drop_cnt  out  16  saturating count of frames dropped while busy.

Function
REQ-008 SHALL write data_caled into buffer[data_caled_address] on data_caled_valid only in state IDLE and only if address < NUM_CH; other writes SHALL be ignored.
REQ-009 SHALL use states IDLE, HDR, DATA (plus CNT, see REQ-020); IDLE->HDR on has_cluster or no_cluster pulse.
REQ-010 SHALL latch left, right, has_cluster and an error flag on the IDLE->HDR transition; error = has_cluster & (left > right | right >= NUM_CH).
REQ-011 SHALL present header one cycle after the triggering pulse: [31:28]=MAGIC, [27]=has_cluster, [26]=error, [25:17]=left, [16:8]=right, [7:0]=0, startofpacket=1.
REQ-012 SHALL, when has_cluster & !error, send samples buffer[left]..buffer[right] in order in DATA, endofpacket on buffer[right].
REQ-013 SHALL, on no_cluster or error, assert endofpacket on the header word and emit no DATA words.
REQ-014 SHALL advance a word only on data_out_valid & data_out_ready; data, sop, eop SHALL hold stable while valid & !ready.
REQ-015 SHALL sustain one word per cycle under continuous ready (buffer read prefetched, RAM latency 1 hidden).
REQ-016 SHALL drive data_out_empty = 0 always; sop and eop SHALL be 0 whenever valid is 0.
REQ-017 SHALL, on has_cluster/no_cluster while not IDLE, ignore the pulse and increment drop_cnt, saturating at 16'hFFFF.
REQ-018 SHALL treat simultaneous has_cluster and no_cluster as has_cluster.
REQ-019 SHALL return to IDLE on the accepted eop beat; a new pulse in that same cycle SHALL count as dropped.

Reset
REQ-020 SHALL, on rst, enter IDLE asynchronously with data_out_valid=0, sop=0, eop=0, data_out_data=0, drop_cnt=0; buffer contents are not cleared.
REQ-021 SHALL abandon a packet in progress on rst with no eop issued; the first post-reset packet SHALL begin with sop.

Configuration
REQ-022 SHALL, with CL_TX_FRAMECNT_EN defined, insert a CNT word (32-bit frame counter, +1 per packet sent, wrapping, reset 0) immediately after the header, header eop moving to the CNT word for no_cluster/error packets.
REQ-023 SHALL, without CL_TX_FRAMECNT_EN, contain no CNT state and no counter register.

Structure
REQ-024 SHALL take state encoding, header field positions, MAGIC default and NUM_CH default from shared package cl_tx_pkg.
REQ-025 SHALL instantiate sub-module cl_tx_buf: simple dual-port 512x32 RAM, one write port, one synchronous read port, read latency 1.

Verification
REQ-026 Write ch0..319 = index, has_cluster left=10 right=13, ready=1 -> header 0xA8_14_0D00 (sop), then 10,11,12,13, eop on 13, five beats in consecutive cycles.
REQ-027 no_cluster pulse -> single word 0xA0000000 with sop=eop=1, then IDLE.
REQ-028 has_cluster left=20 right=5 -> single header word with bit26=1, sop=eop=1.
REQ-029 REQ-026 stimulus with ready toggling every cycle -> identical word sequence, each word held while ready=0.
REQ-030 Second has_cluster during DATA -> ignored, drop_cnt=1; rst mid-DATA -> valid=0 at once, next packet starts with sop.
REQ-031 With CL_TX_FRAMECNT_EN: three no_cluster packets -> CNT words 0,1,2, eop on CNT word.
